// File: rtl/mem_stage.sv
// RV32 memory stage: E/M register, req/ready data port with lane alignment, load extension, stall and timeout.
// Optional MISALIGN_TRAP_EN adds MisalignM and traps misaligned half/word accesses instead of masking them.
module mem_stage #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [2:0]  LOAD_CODE = 3'b001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [2:0]  ResultSrcE,
  input  logic [1:0]  StoreSrcE,
  input  logic [2:0]  LoadSrcE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  output logic        RegWriteM,
  output logic [2:0]  ResultSrcM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] ReadDataM,
  output logic        LoadValidM,
  output logic        StallM,
  output logic        BusErrM,
`ifdef MISALIGN_TRAP_EN
  output logic        MisalignM,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        RegWriteM_q, MemWriteM_q;
  logic [2:0]  ResultSrcM_q, LoadSrcM_q;
  logic [1:0]  StoreSrcM_q;
  logic [31:0] ALUResultM_q, WriteDataM_q, PCPlus4M_q;
  logic [4:0]  RdM_q;

  logic        mem_op, misalign, req_raw, timeout_fire, squash, mem_write;
  logic [1:0]  a;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM_q  <= 1'b0;
      MemWriteM_q  <= 1'b0;
      ResultSrcM_q <= 3'b000;
      StoreSrcM_q  <= 2'b00;
      LoadSrcM_q   <= 3'b000;
      ALUResultM_q <= 32'h0;
      WriteDataM_q <= 32'h0;
      PCPlus4M_q   <= 32'h0;
      RdM_q        <= 5'd0;
    end else if (!StallM) begin
      RegWriteM_q  <= RegWriteE;
      MemWriteM_q  <= MemWriteE;
      ResultSrcM_q <= ResultSrcE;
      StoreSrcM_q  <= StoreSrcE;
      LoadSrcM_q   <= LoadSrcE;
      ALUResultM_q <= ALUResultE;
      WriteDataM_q <= WriteDataE;
      PCPlus4M_q   <= PCPlus4E;
      RdM_q        <= RdE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_op = MemWriteM_q | (ResultSrcM_q == LOAD_CODE);
  assign a      = ALUResultM_q[1:0];

`ifdef MISALIGN_TRAP_EN
  logic is_half, is_word;
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (MemWriteM_q) begin
      is_half = (StoreSrcM_q == 2'b01);
      is_word = (StoreSrcM_q == 2'b00) || (StoreSrcM_q == 2'b11);
    end else begin
      is_half = (LoadSrcM_q == 3'b001) || (LoadSrcM_q == 3'b010);
      is_word = !is_half && (LoadSrcM_q != 3'b011) && (LoadSrcM_q != 3'b100);
    end
  end
  assign misalign  = mem_op & ((is_half & a[0]) | (is_word & (a != 2'b00)));
  assign MisalignM = misalign;
`else
  assign misalign = 1'b0;
`endif

  assign req_raw = mem_op & ~misalign;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_raw && !dmem_ready) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          timeout_fire = ~reset;
          state_d      = S_IDLE;
          cnt_d        = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // The register advances on a squash cycle, so the kill is applied to the values leaving M now.
  assign squash     = timeout_fire | misalign;
  assign mem_write  = MemWriteM_q & ~squash;
  assign dmem_req   = req_raw & ~timeout_fire;
  assign dmem_we    = dmem_req & mem_write;
  assign StallM     = dmem_req & ~dmem_ready & ~timeout_fire;
  assign BusErrM    = timeout_fire;
  assign LoadValidM = dmem_req & dmem_ready & ~mem_write;

  assign RegWriteM  = RegWriteM_q & ~squash;
  assign ResultSrcM = ResultSrcM_q;
  assign RdM        = RdM_q;
  assign ALUResultM = ALUResultM_q;
  assign PCPlus4M   = PCPlus4M_q;
  assign dmem_addr  = {ALUResultM_q[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM_q;
    if (MemWriteM_q) begin
      case (StoreSrcM_q)
        2'b10: begin
          dmem_be    = 4'b0001 << a;
          dmem_wdata = {4{WriteDataM_q[7:0]}};
        end
        2'b01: begin
          dmem_be    = a[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{WriteDataM_q[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM_q;
        end
      endcase
    end
  end

  always_comb begin
    case (a)
      2'b00:   rd_byte = dmem_rdata[7:0];
      2'b01:   rd_byte = dmem_rdata[15:8];
      2'b10:   rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (LoadSrcM_q)
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_ext = {16'h0, rd_half};
      3'b011:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'h0, rd_byte};
      default: load_ext = dmem_rdata;
    endcase
  end

  assign ReadDataM = LoadValidM ? load_ext : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE;
  logic [2:0]  ResultSrcE, LoadSrcE;
  logic [1:0]  StoreSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteM;
  logic [2:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM;
  logic        LoadValidM, StallM, BusErrM;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mis;

`ifdef MISALIGN_TRAP_EN
  logic MisalignM;
  assign mis = MisalignM;
`else
  assign mis = 1'b0;
`endif

  mem_stage #(.TIMEOUT(4), .LOAD_CODE(3'b001)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .StoreSrcE(StoreSrcE), .LoadSrcE(LoadSrcE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
    .LoadValidM(LoadValidM), .StallM(StallM), .BusErrM(BusErrM),
`ifdef MISALIGN_TRAP_EN
    .MisalignM(MisalignM),
`endif
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 access completes, 1 bus error, 2 misalign trap
  typedef struct {
    logic [1:0]  kind;
    int          stalls;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        lv;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  exp_t em;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] kind, input int stalls, input logic rw,
                              input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] be,
                              input logic we, input logic [31:0] wdata, input logic lv,
                              input logic [31:0] rdata);
    exp_t e;
    e.kind = kind; e.stalls = stalls; e.rw = rw; e.rd = rd; e.addr = addr;
    e.be = be; e.we = we; e.wdata = wdata; e.lv = lv; e.rdata = rdata;
    return e;
  endfunction

  task automatic set_e(input logic rw, input logic mw, input logic [2:0] rs, input logic [1:0] ss,
                       input logic [2:0] ls, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] rd);
    RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; StoreSrcE = ss; LoadSrcE = ls;
    ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc; RdE = rd;
  endtask

  task automatic bubble();
    set_e(1'b0, 1'b0, 3'b000, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  // delay = M cycle index in which ready is given; negative means never
  task automatic issue(input logic rw, input logic mw, input logic [2:0] rs, input logic [1:0] ss,
                       input logic [2:0] ls, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                       input exp_t e);
    int  k;
    bit  done;
    @(posedge clk); #1;
    set_e(rw, mw, rs, ss, ls, alu, wd, alu + 32'd4, rd);
    dmem_ready = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bubble();
    k = 0;
    done = 0;
    while (!done && k < 40) begin
      dmem_ready = (k == delay);
      dmem_rdata = rdata;
      @(negedge clk);
      if (!StallM) done = 1;
      @(posedge clk); #1;
      k++;
    end
    dmem_ready = 1'b0;
    if (!done) check("issue_left_M", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
    end else if ((dmem_req && dmem_ready) || BusErrM || mis) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: req=%0b ready=%0b buserr=%0b mis=%0b expected none",
                 dmem_req, dmem_ready, BusErrM, mis);
      end else begin
        em = exp_q.pop_front();
        check("kind", BusErrM ? 32'd1 : (mis ? 32'd2 : 32'd0), 32'(em.kind));
        check("stall_cycles", 32'(stall_cnt), 32'(em.stalls));
        check("RegWriteM", 32'(RegWriteM), 32'(em.rw));
        check("RdM", 32'(RdM), 32'(em.rd));
        if (em.kind == 2'd0) begin
          check("dmem_addr", dmem_addr, em.addr);
          check("dmem_be", 32'(dmem_be), 32'(em.be));
          check("dmem_we", 32'(dmem_we), 32'(em.we));
          if (em.we) check("dmem_wdata", dmem_wdata, em.wdata);
          check("LoadValidM", 32'(LoadValidM), 32'(em.lv));
          check("ReadDataM", ReadDataM, em.rdata);
        end else begin
          check("dmem_req_on_fault", 32'(dmem_req), 32'd0);
        end
      end
      stall_cnt = 0;
    end else if (StallM) begin
      stall_cnt++;
    end
  end

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_StallM", 32'(StallM), 32'd0);
    check("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    check("rst_ALUResultM", ALUResultM, 32'd0);
    check("rst_BusErrM", 32'(BusErrM), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // sb 0x103 <- 0xAB, ready immediately
    issue(0, 1, 3'b000, 2'b10, 3'b000, 32'h103, 32'hAB, 5'd0, 0, 32'h0,
          mk(0, 0, 0, 5'd0, 32'h100, 4'b1000, 1, 32'hABABABAB, 0, 32'h0));
    // lh 0x202, ready in 4th M cycle
    issue(1, 0, 3'b001, 2'b00, 3'b001, 32'h202, 32'h0, 5'd5, 3, 32'h8001_0000,
          mk(0, 3, 1, 5'd5, 32'h200, 4'b1111, 0, 32'h0, 1, 32'hFFFF8001));
    // lhu 0x202
    issue(1, 0, 3'b001, 2'b00, 3'b010, 32'h202, 32'h0, 5'd6, 0, 32'h8001_0000,
          mk(0, 0, 1, 5'd6, 32'h200, 4'b1111, 0, 32'h0, 1, 32'h00008001));
    // lbu 0x301
    issue(1, 0, 3'b001, 2'b00, 3'b100, 32'h301, 32'h0, 5'd7, 1, 32'h0000_F700,
          mk(0, 1, 1, 5'd7, 32'h300, 4'b1111, 0, 32'h0, 1, 32'h000000F7));
    // lb 0x301
    issue(1, 0, 3'b001, 2'b00, 3'b011, 32'h301, 32'h0, 5'd8, 0, 32'h0000_F700,
          mk(0, 0, 1, 5'd8, 32'h300, 4'b1111, 0, 32'h0, 1, 32'hFFFFFFF7));
    // sh 0x206 <- 0x1234ABCD
    issue(0, 1, 3'b000, 2'b01, 3'b000, 32'h206, 32'h1234ABCD, 5'd0, 2, 32'h0,
          mk(0, 2, 0, 5'd0, 32'h204, 4'b1100, 1, 32'hABCDABCD, 0, 32'h0));
    // lw 0x400
    issue(1, 0, 3'b001, 2'b00, 3'b000, 32'h400, 32'h0, 5'd9, 0, 32'hDEADBEEF,
          mk(0, 0, 1, 5'd9, 32'h400, 4'b1111, 0, 32'h0, 1, 32'hDEADBEEF));
    // lw 0x500, never ready: 4 stall cycles then bus error, write squashed
    issue(1, 0, 3'b001, 2'b00, 3'b000, 32'h500, 32'h0, 5'd10, -1, 32'h0,
          mk(1, 4, 0, 5'd10, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0));
    // sb 0x000 <- 0x5A after the error
    issue(0, 1, 3'b000, 2'b10, 3'b000, 32'h0, 32'h5A, 5'd0, 0, 32'h0,
          mk(0, 0, 0, 5'd0, 32'h0, 4'b0001, 1, 32'h5A5A5A5A, 0, 32'h0));
    // sw 0x402
`ifdef MISALIGN_TRAP_EN
    issue(0, 1, 3'b000, 2'b00, 3'b000, 32'h402, 32'hCAFEF00D, 5'd0, 0, 32'h0,
          mk(2, 0, 0, 5'd0, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0));
`else
    issue(0, 1, 3'b000, 2'b00, 3'b000, 32'h402, 32'hCAFEF00D, 5'd0, 0, 32'h0,
          mk(0, 0, 0, 5'd0, 32'h400, 4'b1111, 1, 32'hCAFEF00D, 0, 32'h0));
`endif

    // non-memory ALU op: no request, no stall, fields pass through
    @(posedge clk); #1;
    set_e(1, 0, 3'b000, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h44, 5'd7);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    check("alu_dmem_req", 32'(dmem_req), 32'd0);
    check("alu_StallM", 32'(StallM), 32'd0);
    check("alu_RegWriteM", 32'(RegWriteM), 32'd1);
    check("alu_ALUResultM", ALUResultM, 32'h1234);
    check("alu_PCPlus4M", PCPlus4M, 32'h44);
    check("alu_RdM", 32'(RdM), 32'd7);

    // reset while waiting on a load
    @(posedge clk); #1;
    set_e(1, 0, 3'b001, 2'b00, 3'b000, 32'h600, 32'h0, 32'h604, 5'd3);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    bubble();
    @(posedge clk);
    @(negedge clk);
    check("wait_StallM", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rwait_dmem_req", 32'(dmem_req), 32'd0);
    check("rwait_StallM", 32'(StallM), 32'd0);
    check("rwait_BusErrM", 32'(BusErrM), 32'd0);
    check("rwait_RegWriteM", 32'(RegWriteM), 32'd0);
    check("rwait_ResultSrcM", 32'(ResultSrcM), 32'd0);
    check("rwait_RdM", 32'(RdM), 32'd0);
    check("rwait_ALUResultM", ALUResultM, 32'd0);
    check("rwait_PCPlus4M", PCPlus4M, 32'd0);
    check("rwait_ReadDataM", ReadDataM, 32'd0);
    check("rwait_LoadValidM", 32'(LoadValidM), 32'd0);

    // operation resumes after reset
    issue(1, 0, 3'b001, 2'b00, 3'b000, 32'h700, 32'h0, 5'd4, 1, 32'h0BAD_F00D,
          mk(0, 1, 1, 5'd4, 32'h700, 4'b1111, 0, 32'h0, 1, 32'h0BADF00D));

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-stage block of the 5-stage RV32 pipeline; consumes everything the Execute stage produces.
- Holds the E/M pipeline register and drives a req/ready data-memory port with byte-lane alignment and load sign/zero extension.
- Generates the stall for upstream stages while memory is busy.
- Exposes ALUResultM, RdM and RegWriteM to the hazard/forwarding unit.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before a bus error is declared (1..255).
- LOAD_CODE, 3'b001: ResultSrc value that marks a load.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- RegWriteE  in  1  register-write enable from Execute.
- MemWriteE  in  1  store enable.
- ResultSrcE  in  3  writeback mux select.
- StoreSrcE  in  2  store size: 00 word, 01 half, 10 byte.
- LoadSrcE  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
- ALUResultE  in  32  address or ALU result.
- WriteDataE  in  32  forwarded store data.
- PCPlus4E  in  32  link value.
- RdE  in  5  destination register.
- RegWriteM  out  1  registered copy.
- ResultSrcM  out  3  registered copy.
- RdM  out  5  registered copy.
- ALUResultM  out  32  registered copy; forwarding source.
- PCPlus4M  out  32  registered copy.
- ReadDataM  out  32  extended load data.
- LoadValidM  out  1  ReadDataM valid this cycle.
- StallM  out  1  freeze PC/F/D/E and this register.
- BusErrM  out  1  one-cycle pulse on timeout.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word address, bits[1:0] = 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ready  in  1  access complete; rdata valid when read.
- dmem_rdata  in  32  read word.

Behaviour:
- E/M register: loads all E inputs on the clock edge when StallM = 0. Holds when StallM = 1.
- Reset: clears every registered output and state to 0, state = IDLE, timeout counter = 0, dmem_req = 0.
- Reset mid-WAIT: the access is abandoned; no BusErrM pulse.
- Memory op: MemOpM = MemWriteM | (ResultSrcM == LOAD_CODE).
- FSM states IDLE and WAIT:
  - dmem_req = MemOpM & (state IDLE or WAIT). The request is issued in the first M cycle.
  - IDLE, MemOpM and dmem_ready: access completes with zero wait; no stall.
  - IDLE, MemOpM and no ready: go to WAIT, counter = 1.
  - WAIT, ready: go to IDLE.
  - WAIT, no ready and counter == TIMEOUT: pulse BusErrM, drop req, force RegWriteM = 0 and MemWriteM = 0 in the register (instruction squashed), go to IDLE.
  - Otherwise in WAIT: counter increments.
- StallM = dmem_req & ~dmem_ready & ~timeout_fire.
- Address, data and byte-lane rules:
  - dmem_addr = {ALUResultM[31:2], 2'b00}. Lane a = ALUResultM[1:0].
  - Byte store: be = 1 << a; wdata = byte replicated ×4.
  - Half store: be = 0011 << {a[1], 0}; wdata = half replicated ×2.
  - Word store: be = 1111.
  - Loads drive be = 1111.
  - Loads select the lane the same way, then sign- or zero-extend per LoadSrcM.
- LoadValidM = dmem_req & dmem_ready & ~MemWriteM.
- ReadDataM is combinational from dmem_rdata while LoadValidM = 1; otherwise 0.
- A non-memory instruction never asserts dmem_req and never stalls.
- Back-to-back memory ops each start in IDLE on the cycle after the previous one completes.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: adds output MisalignM (1 bit).
  - An access is misaligned when it is a half with a[0] = 1, or a word with a ≠ 00.
  - A misaligned access never raises dmem_req.
  - It pulses MisalignM for one cycle and squashes RegWriteM the same way as a timeout.
- Undefined: no port. Low address bits are masked to natural alignment: half ignores a[0], word ignores a[1:0]. The access proceeds.

Test Plan:
- sb: ALUResultE = 0x103, WriteDataE = 0xAB, ready = 1 in the same cycle → dmem_addr = 0x100, be = 1000, wdata = 0xABABABAB, StallM never 1.
- lh: addr 0x202, rdata = 0x8001_0000, ready after 3 cycles → StallM high for 3 cycles, then LoadValidM = 1, ReadDataM = 0xFFFF8001.
- lbu: addr 0x301, rdata = 0x0000_F700 → ReadDataM = 0x000000F7.
- TIMEOUT = 4, ready held 0 → StallM high for 4 cycles, BusErrM pulses once, RegWriteM = 0, next instruction proceeds.
- reset asserted during WAIT → next cycle dmem_req = 0, StallM = 0, all outputs 0, no BusErrM.
- MISALIGN_TRAP_EN defined, sw at 0x402 → MisalignM = 1 for one cycle, dmem_req = 0. Undefined → be = 1111, addr 0x400.
